memory: RTL and testbench

MEMORY -- requirements
Module: memory

---
 rtl/memory_pkg.sv | 14 +
 rtl/memory_hs_fsm.sv | 35 +++
 rtl/memory.sv | 74 +++++++
 tb/tb_memory.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// memory_pkg: shared types and default sizing for the memory block.
// The handshake state type is only used when MEMORY_WAIT_STATE_EN is defined.
package memory_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } hs_state_e;

endpackage

// File: rtl/memory_hs_fsm.sv
// memory_hs_fsm: wait-state handshake sequencer (IDLE -> WAIT -> ACK).
// Instantiated by memory only when MEMORY_WAIT_STATE_EN is defined.
module memory_hs_fsm
  import memory_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic ready_o
);

  hs_state_e state_q;
  hs_state_e state_d;

  // Next-state logic: one wait cycle, abort back to IDLE if the request drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = WAIT;
      WAIT:    state_d = valid_i ? ACK : IDLE;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset parks the sequencer in IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Ready is a pure state decode so it never glitches with valid_i.
  assign ready_o = (state_q == ACK);

endmodule

// File: rtl/memory.sv
// memory: single-port word memory with a valid/ready handshake and a
// registered read port. Define MEMORY_WAIT_STATE_EN to insert one wait
// state per transfer (handled by memory_hs_fsm); otherwise ready follows
// valid in the same cycle.
module memory
  import memory_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  valid_i,
  input  logic                  wr_rd_en_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  ready_o
);

  // Widened by one bit so DEPTH itself is representable for the range check.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;
  logic             hs;
  logic             addr_ok;

`ifdef MEMORY_WAIT_STATE_EN
  memory_hs_fsm u_hs_fsm (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o)
  );
`else
  // Zero wait states; reset still forces ready low.
  assign ready_o = valid_i & ~rst_i;
`endif

  assign hs      = valid_i & ready_o;
  // Out-of-range addresses only exist when DEPTH is not a power of two.
  assign addr_ok = ({1'b0, addr_i} < DEPTH_LIM);

  // Next storage and read-register values for the current handshake.
  always_comb begin
    mem_d   = mem_q;
    rdata_d = rdata_q;
    if (hs) begin
      if (wr_rd_en_i) begin
        if (addr_ok) mem_d[addr_i] = wdata_i;
      end else begin
        rdata_d = addr_ok ? mem_q[addr_i] : '0;
      end
    end
  end

  // Storage and read register; reset wipes every word so no partial write survives.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_memory.sv
// tb_memory: directed, table-driven bench for memory (default 4x16).
// Covers both builds; MEMORY_WAIT_STATE_EN selects the latency checks.
module tb_memory;

  logic       clk;
  logic       rst;
  logic [3:0] wdata;
  logic [3:0] addr;
  logic       valid;
  logic       wr;
  logic [3:0] rdata;
  logic       ready;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] model [16];

  typedef struct {
    bit         v;
    bit         w;
    logic [3:0] a;
    logic [3:0] d;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [13];

  memory dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wdata_i    (wdata),
    .addr_i     (addr),
    .valid_i    (valid),
    .wr_rd_en_i (wr),
    .rdata_o    (rdata),
    .ready_o    (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One transaction: hold valid until ready, then finish on the handshake edge.
  task automatic do_txn(input logic w, input logic [3:0] a, input logic [3:0] d);
    bit ok;
    @(negedge clk);
    valid = 1'b1; wr = w; addr = a; wdata = d;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
      if (w) model[a] = d;
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL handshake_timeout: got ready=0, expected ready=1 within 10 cycles");
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 4'h3, 4'hA, 4'h0};
    tbl[1]  = '{1'b1, 1'b0, 4'h3, 4'h0, 4'hA};
    tbl[2]  = '{1'b1, 1'b1, 4'h0, 4'h5, 4'hA};
    tbl[3]  = '{1'b1, 1'b1, 4'hF, 4'hF, 4'hA};
    tbl[4]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h5};
    tbl[5]  = '{1'b1, 1'b0, 4'hF, 4'h0, 4'hF};
    tbl[6]  = '{1'b0, 1'b1, 4'h0, 4'h9, 4'hF};
    tbl[7]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h5};
    tbl[8]  = '{1'b1, 1'b1, 4'h7, 4'h6, 4'h5};
    tbl[9]  = '{1'b1, 1'b1, 4'h7, 4'hC, 4'h5};
    tbl[10] = '{1'b1, 1'b0, 4'h7, 4'h0, 4'hC};
    tbl[11] = '{1'b0, 1'b0, 4'h3, 4'h0, 4'hC};
    tbl[12] = '{1'b1, 1'b0, 4'h3, 4'h0, 4'hA};

    for (int i = 0; i < 16; i++) model[i] = 4'h0;

    // Reset: request pending during reset must not see ready.
    rst = 1'b1; valid = 1'b1; wr = 1'b1; addr = 4'h1; wdata = 4'h7;
    #7;
    chk("reset_rdata", rdata, 4'h0);
    chk("reset_ready", {3'b0, ready}, 4'h0);
    #13;
    rst = 1'b0; valid = 1'b0;
    for (int a = 0; a < 16; a++) begin
      do_txn(1'b0, 4'(a), 4'h0);
      chk($sformatf("reset_read_%0d", a), rdata, 4'h0);
    end
    go_idle();

    // Directed table: back-to-back transfers, idle cycles that must be ignored.
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].v) begin
        do_txn(tbl[i].w, tbl[i].a, tbl[i].d);
      end else begin
        @(negedge clk);
        valid = 1'b0; wr = tbl[i].w; addr = tbl[i].a; wdata = tbl[i].d;
        #1;
        chk($sformatf("vec%0d_ready", i), {3'b0, ready}, 4'h0);
        @(posedge clk);
        #1;
      end
      chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp);
    end
    go_idle();

    // Full write / read-back pass with random data.
    for (int a = 0; a < 16; a++) do_txn(1'b1, 4'(a), 4'($urandom_range(0, 15)));
    for (int a = 0; a < 16; a++) begin
      do_txn(1'b0, 4'(a), 4'h0);
      chk($sformatf("pass_read_%0d", a), rdata, model[a]);
    end
    go_idle();

    // Write then read the same address in the next cycle.
    do_txn(1'b1, 4'h3, 4'hA);
    do_txn(1'b0, 4'h3, 4'h0);
    chk("wr_then_rd", rdata, 4'hA);
    go_idle();

`ifdef MEMORY_WAIT_STATE_EN
    // Latency: valid seen at edge N, ready in cycle N+1, transfer at edge N+2.
    @(negedge clk);
    valid = 1'b1; wr = 1'b1; addr = 4'h2; wdata = ~model[2];
    #1;
    chk("lat_ready_pre", {3'b0, ready}, 4'h0);
    @(posedge clk); #1;
    chk("lat_ready_n", {3'b0, ready}, 4'h0);
    @(posedge clk); #1;
    chk("lat_ready_n1", {3'b0, ready}, 4'h1);
    @(posedge clk); #1;
    chk("lat_ready_n2", {3'b0, ready}, 4'h0);
    model[2] = wdata;
    go_idle();
    do_txn(1'b0, 4'h2, 4'h0);
    chk("lat_readback", rdata, model[2]);
    go_idle();

    // Abort from WAIT: dropping valid must cancel the write.
    @(negedge clk);
    valid = 1'b1; wr = 1'b1; addr = 4'h9; wdata = ~model[9];
    @(posedge clk); #1;
    chk("abort_ready_wait", {3'b0, ready}, 4'h0);
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready_1", {3'b0, ready}, 4'h0);
    @(posedge clk); #1;
    chk("abort_ready_2", {3'b0, ready}, 4'h0);
    do_txn(1'b0, 4'h9, 4'h0);
    chk("abort_readback", rdata, model[9]);
    go_idle();
`else
    // Zero wait states: ready follows valid within the same cycle.
    @(negedge clk);
    valid = 1'b1; wr = 1'b0; addr = 4'h3;
    #1;
    chk("lat_ready_hi", {3'b0, ready}, 4'h1);
    valid = 1'b0;
    #1;
    chk("lat_ready_lo", {3'b0, ready}, 4'h0);
`endif

    // Reset asserted while a write to addr 5 is pending.
    do_txn(1'b0, 4'h3, 4'h0);
    @(negedge clk);
    valid = 1'b1; wr = 1'b1; addr = 4'h5; wdata = 4'hF;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ready", {3'b0, ready}, 4'h0);
    chk("midrst_rdata", rdata, 4'h0);
    #20;
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 4'h0;
    do_txn(1'b0, 4'h5, 4'h0);
    chk("midrst_addr5", rdata, 4'h0);
    do_txn(1'b0, 4'h3, 4'h0);
    chk("midrst_addr3", rdata, 4'h0);
    go_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
